prog_loader: RTL and testbench

Host-side writer that fills the processor's 256x16 memory before execution; the controller/IR path is the reader of the same memory port. It accepts a byte stream over a valid/ready handshake, assembles 16-bit words (low byte first), and issues single-cycle memory writes at incrementing addresses. While loading it holds the processor core in reset via cpu_hold, then releases it.

---
 rtl/prog_loader.sv | 168 ++++++++++++++++
 tb/tb_prog_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: fills the 256x16 program memory, holding the core in reset while loading.
// Optional checksum byte and error flag: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] words_loaded
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_LO, S_HI, S_WR, S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
      , S_CHK
`endif
   } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t S_FIN = S_CHK;
`else
   localparam state_t S_FIN = S_DONE;
`endif

   state_t            state_q, state_d;
   logic              rdy_q, rdy_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wl_q, wl_d;
   logic [ADDR_W-1:0] wl_inc;
   logic [DATA_W-1:0] word_q, word_d;
   logic              xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              err_q, err_d;
`endif

   assign xfer   = in_valid & rdy_q;
   assign wl_inc = wl_q + ADDR_W'(1);

   // Next-state logic: handshake sequencing, word assembly, address stepping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wl_d    = wl_q;
      word_d  = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_HDR;
               wl_d    = '0;
               addr_d  = BASE;
`ifdef PROG_LOADER_CHECKSUM_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_HDR: begin
            if (xfer) begin
               cnt_d   = ADDR_W'(in_data);
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d   = in_data;
`endif
               state_d = (in_data == 8'd0) ? S_FIN : S_LO;
            end
         end
         S_LO: begin
            if (xfer) begin
               word_d[7:0] = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d       = sum_q + in_data;
`endif
               state_d     = S_HI;
            end
         end
         S_HI: begin
            if (xfer) begin
               word_d[15:8] = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d        = sum_q + in_data;
`endif
               state_d      = S_WR;
            end
         end
         S_WR: begin
            addr_d  = addr_q + ADDR_W'(1);
            wl_d    = wl_inc;
            state_d = (wl_inc == cnt_q) ? S_FIN : S_LO;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) begin
               err_d   = ((sum_q + in_data) != 8'd0);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      rdy_d = (state_d == S_HDR) || (state_d == S_LO) ||
              (state_d == S_HI)
`ifdef PROG_LOADER_CHECKSUM_EN
              || (state_d == S_CHK)
`endif
              ;
   end

   // State and datapath registers; reset aborts any session immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         rdy_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= BASE;
         wl_q    <= '0;
         word_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wl_q    <= wl_d;
         word_q  <= word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign in_ready     = rdy_q;
   assign mem_wr       = (state_q == S_WR);
   assign mem_addr     = addr_q;
   assign mem_data     = word_q;
   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign cpu_hold     = busy;
   assign done         = (state_q == S_DONE);
   assign words_loaded = wl_q;
`ifdef PROG_LOADER_CHECKSUM_EN
   assign error        = err_q;
`else
   assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stream sessions, reset abort, header 0, base wrap.
// Checksum cases run when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        in_ready, mem_wr, cpu_hold, busy, done, error;
   logic [7:0]  mem_addr, words_loaded;
   logic [15:0] mem_data;

   logic        in_ready1, mem_wr1, cpu_hold1, busy1, done1, error1;
   logic [7:0]  mem_addr1, words_loaded1;
   logic [15:0] mem_data1;

   int checks = 0;
   int failures = 0;

   logic [7:0]  bq[$];
   logic [7:0]  a0[$], a1[$];
   logic [15:0] d0[$], d1[$];
   int          rdy_wr_err = 0;
   int          hold_err = 0;
   int          ncyc;

   prog_loader #(.BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .error(error), .words_loaded(words_loaded)
   );

   prog_loader #(.BASE_ADDR(8'hFE)) dut_hi (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .mem_wr(mem_wr1),
      .mem_addr(mem_addr1), .mem_data(mem_data1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1),
      .error(error1), .words_loaded(words_loaded1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_wr) begin
         a0.push_back(mem_addr);
         d0.push_back(mem_data);
         if (in_ready) rdy_wr_err++;
      end
      if (mem_wr1) begin
         a1.push_back(mem_addr1);
         d1.push_back(mem_data1);
      end
      if (busy && !cpu_hold) hold_err++;
   end

   task automatic clr();
      a0.delete(); d0.delete();
      a1.delete(); d1.delete();
      rdy_wr_err = 0;
      hold_err = 0;
   endtask

   task automatic go(input bit tog, input int spulse, input bit addck);
      int idx;
      int cyc;
      logic [7:0] s;
      s = 8'h00;
      foreach (bq[i]) s = s + bq[i];
      if (addck && CK != 0) bq.push_back(8'h00 - s);
      clr();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      cyc = 0;
      while (!done && cyc < 400) begin
         start = (cyc == spulse);
         in_valid = (idx < bq.size()) && (!tog || (cyc % 2 == 0));
         in_data = (idx < bq.size()) ? bq[idx] : 8'h00;
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      ncyc = cyc;
      if (cyc >= 400) chk("timeout", 32'(cyc), 32'd0);
   endtask

   initial begin
      #12;
      chk("rst_ready", in_ready, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", error, 0);
      @(negedge clk);
      reset = 1'b0;

      bq = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
      go(1'b0, -1, 1'b1);
      chk("t1_nwr", a0.size(), 2);
      chk("t1_a0", a0[0], 8'h00);
      chk("t1_d0", d0[0], 16'h1234);
      chk("t1_a1", a0[1], 8'h01);
      chk("t1_d1", d0[1], 16'hABCD);
      chk("t1_cyc", ncyc, 7 + CK);
      chk("t1_done", done, 1);
      chk("t1_words", words_loaded, 2);
      chk("t1_hold", cpu_hold, 0);
      chk("t1_holderr", hold_err, 0);
      chk("t1_err", error, 0);

      bq = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
      go(1'b1, -1, 1'b1);
      chk("t2_nwr", a0.size(), 2);
      chk("t2_d0", d0[0], 16'h1234);
      chk("t2_d1", d0[1], 16'hABCD);
      chk("t2_a1", a0[1], 8'h01);
      chk("t2_rdywr", rdy_wr_err, 0);
      chk("t2_words", words_loaded, 2);

      clr();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t3_hold_hdr", cpu_hold, 1);
      in_valid = 1'b1;
      in_data = 8'h02;
      @(negedge clk);
      in_data = 8'h34;
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("t3_ready", in_ready, 0);
      chk("t3_hold", cpu_hold, 0);
      chk("t3_busy", busy, 0);
      chk("t3_wr", mem_wr, 0);
      chk("t3_data", mem_data, 0);
      chk("t3_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("t3_nwr", a0.size(), 0);
      chk("t3_idle", busy, 0);

      bq = '{8'h00};
      go(1'b0, -1, 1'b1);
      chk("t4_nwr", a0.size(), 0);
      chk("t4_done", done, 1);
      chk("t4_words", words_loaded, 0);
      chk("t4_cyc", ncyc, 1 + CK);

      bq = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      go(1'b0, 4, 1'b1);
      chk("t5_nwr", a0.size(), 3);
      chk("t5_d0", d0[0], 16'h2211);
      chk("t5_d1", d0[1], 16'h4433);
      chk("t5_d2", d0[2], 16'h6655);
      chk("t5_a2", a0[2], 8'h02);
      chk("t5_words", words_loaded, 3);
      chk("t5_cyc", ncyc, 10 + CK);
      chk("t6_nwr", a1.size(), 3);
      chk("t6_a0", a1[0], 8'hFE);
      chk("t6_a1", a1[1], 8'hFF);
      chk("t6_a2", a1[2], 8'h00);
      chk("t6_d2", d1[2], 16'h6655);

`ifdef PROG_LOADER_CHECKSUM_EN
      bq = '{8'h01, 8'h34, 8'h12, 8'hB9};
      go(1'b0, -1, 1'b0);
      chk("ck_ok_done", done, 1);
      chk("ck_ok_err", error, 0);
      chk("ck_ok_d", d0[0], 16'h1234);
      bq = '{8'h01, 8'h34, 8'h12, 8'h00};
      go(1'b0, -1, 1'b0);
      chk("ck_bad_done", done, 1);
      chk("ck_bad_err", error, 1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ck_clr_err", error, 0);
      chk("ck_clr_busy", busy, 1);
`else
      chk("nock_err", error, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
